// File: rtl/pkt_dump_pkg.sv
// Shared types and constants for the capture-RAM dump controller.
package pkt_dump_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ARM,
        WAIT,
        SOF,
        LEN_HI,
        LEN_LO,
        FETCH,
        DATA,
        CSUM,
        GAP
    } dumpState_e;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;
    localparam int         HDR_BYTES        = 3;

    // Two's complement of the running sum, so that sum(data) + checksum == 0 mod 256.
    function automatic logic [7:0] csumByte(input logic [7:0] sum);
        return (~sum) + 8'd1;
    endfunction

endpackage

// File: rtl/pkt_dump_ctrl.sv
// Arms the capture RAM, waits for a frame, then streams it as
// SOF, length hi, length lo, data bytes, checksum toward the UART.
module pkt_dump_ctrl
    import pkt_dump_pkg::*;
#(
    parameter int         ADDR_W     = 12,
    parameter int         MAX_LEN    = 1518,
    parameter logic [7:0] SOF_BYTE   = SOF_BYTE_DEFAULT,
    parameter int         GAP_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    output logic              capture,
    input  logic              done,
    input  logic [ADDR_W-1:0] pkt_length,
    output logic [ADDR_W-1:0] pkt_addr,
    input  logic [7:0]        pkt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              busy,
    output logic [15:0]       pkt_count,
    output logic              len_clamped
);

    if (MAX_LEN < 1 || MAX_LEN >= (1 << ADDR_W) || ADDR_W > 16 || GAP_CYCLES < 0) begin : g_bad_params
        $error("pkt_dump_ctrl: MAX_LEN must fit in ADDR_W bits, ADDR_W <= 16, GAP_CYCLES >= 0");
    end

    localparam int                GAP_W     = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);
    localparam logic [ADDR_W-1:0] MAX_LEN_A = ADDR_W'(MAX_LEN);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES);

    dumpState_e        state_q;
    logic              capture_q;
    logic [ADDR_W-1:0] pktAddr_q;
    logic              outValid_q;
    logic [7:0]        outData_q;
    logic [15:0]       pktCount_q;
    logic              lenClamped_q;
    logic [GAP_W-1:0]  gapCnt_q;
    logic [7:0]        csum_q;
    logic [ADDR_W-1:0] len_q;

    logic              xfer;
    logic [ADDR_W-1:0] len_d;
    logic [7:0]        csum_d;
    logic [15:0]       lenWide;
    logic [ADDR_W-1:0] lenLast;
    logic              tooLong;

    assign xfer    = outValid_q && out_ready;
    assign tooLong = (pkt_length > MAX_LEN_A);
    assign len_d   = tooLong ? MAX_LEN_A : pkt_length;
    assign csum_d  = csum_q + outData_q;
    assign lenWide = 16'(len_q);
    assign lenLast = len_q - ADDR_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            capture_q    <= 1'b0;
            pktAddr_q    <= '0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            pktCount_q   <= '0;
            lenClamped_q <= 1'b0;
            gapCnt_q     <= '0;
            csum_q       <= '0;
            len_q        <= '0;
        end else begin
            capture_q    <= 1'b0;
            lenClamped_q <= 1'b0;

            unique case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q   <= ARM;
                        capture_q <= 1'b1;
                    end
                end

                ARM: begin
                    state_q <= WAIT;
                end

                // No timeout here: the RAM is already armed and will report eventually.
                WAIT: begin
                    if (done) begin
                        len_q        <= len_d;
                        lenClamped_q <= tooLong;
                        if (len_d == '0) begin
                            state_q  <= GAP;
                            gapCnt_q <= '0;
                        end else begin
                            state_q    <= SOF;
                            outValid_q <= 1'b1;
                            outData_q  <= SOF_BYTE;
                        end
                    end
                end

                SOF: begin
                    if (xfer) begin
                        state_q   <= LEN_HI;
                        outData_q <= lenWide[15:8];
                    end
                end

                LEN_HI: begin
                    if (xfer) begin
                        state_q   <= LEN_LO;
                        outData_q <= lenWide[7:0];
                    end
                end

                LEN_LO: begin
                    if (xfer) begin
                        state_q    <= FETCH;
                        outValid_q <= 1'b0;
                        pktAddr_q  <= '0;
                        csum_q     <= '0;
                    end
                end

                // pkt_addr has been stable for a full clock, so pkt_data now matches it.
                FETCH: begin
                    state_q    <= DATA;
                    outValid_q <= 1'b1;
                    outData_q  <= pkt_data;
                end

                DATA: begin
                    if (xfer) begin
                        csum_q <= csum_d;
                        if (pktAddr_q == lenLast) begin
                            state_q   <= CSUM;
                            outData_q <= csumByte(csum_d);
                        end else begin
                            state_q    <= FETCH;
                            outValid_q <= 1'b0;
                            pktAddr_q  <= pktAddr_q + ADDR_W'(1);
                        end
                    end
                end

                CSUM: begin
                    if (xfer) begin
                        state_q    <= GAP;
                        outValid_q <= 1'b0;
                        pktCount_q <= pktCount_q + 16'd1;
                        gapCnt_q   <= '0;
                    end
                end

                // Occupies GAP_CYCLES + 1 clocks, so a zero gap still spends one cycle here.
                GAP: begin
                    if (gapCnt_q == GAP_LAST) begin
                        if (enable) begin
                            state_q   <= ARM;
                            capture_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gapCnt_q <= gapCnt_q + GAP_W'(1);
                    end
                end

                default: begin
                    state_q    <= IDLE;
                    outValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign capture     = capture_q;
    assign pkt_addr    = pktAddr_q;
    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign busy        = (state_q != IDLE);
    assign pkt_count   = pktCount_q;
    assign len_clamped = lenClamped_q;

endmodule

// File: tb/tb_pkt_dump_ctrl.sv
// Directed bench for pkt_dump_ctrl: a frame table plus hand-written
// sequences for gap timing, backpressure, enable drop and mid-frame reset.
module tb_pkt_dump_ctrl;

    localparam int         ADDR_W     = 12;
    localparam int         MAX_LEN    = 1518;
    localparam int         GAP_CYCLES = 16;
    localparam logic [7:0] SOF        = 8'hA5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable = 1'b0;
    logic              capture;
    logic              done = 1'b0;
    logic [ADDR_W-1:0] pkt_length;
    logic [ADDR_W-1:0] pkt_addr;
    logic [7:0]        pkt_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [7:0]        out_data;
    logic              busy;
    logic [15:0]       pkt_count;
    logic              len_clamped;

    pkt_dump_ctrl #(
        .ADDR_W     (ADDR_W),
        .MAX_LEN    (MAX_LEN),
        .SOF_BYTE   (SOF),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .capture     (capture),
        .done        (done),
        .pkt_length  (pkt_length),
        .pkt_addr    (pkt_addr),
        .pkt_data    (pkt_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .pkt_count   (pkt_count),
        .len_clamped (len_clamped)
    );

    always #5 clk = ~clk;

    // Capture RAM model: capture clears done, which returns a few clocks later.
    logic [7:0]        mem [0:4095];
    logic [ADDR_W-1:0] ramLen = '0;
    int                doneDelay = 0;

    assign pkt_length = ramLen;
    always_comb pkt_data = mem[pkt_addr];

    always @(posedge clk) begin
        if (capture) begin
            done      <= 1'b0;
            doneDelay <= 4;
        end else if (doneDelay != 0) begin
            doneDelay <= doneDelay - 1;
            if (doneDelay == 1) done <= 1'b1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stream monitor: a byte seen valid&&ready here moves on the next rising edge.
    logic [7:0] streamQ [$];
    int         xferCyc [$];
    int         capCount = 0;
    int         clampCount = 0;
    int         addrOver = 0;
    int         doneRiseCyc = 0;
    logic       doneLast = 1'b0;

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            streamQ.push_back(out_data);
            xferCyc.push_back(cyc);
        end
        if (capture) capCount = capCount + 1;
        if (len_clamped) clampCount = clampCount + 1;
        if (busy && pkt_addr >= ADDR_W'(MAX_LEN)) addrOver = addrOver + 1;
        if (done && !doneLast) doneRiseCyc = cyc;
        doneLast = done;
    end

    typedef struct {
        int         len;
        int         mul;
        int         add;
        int         expClamp;
        logic [7:0] expHi;
        logic [7:0] expLo;
        int         expN;
        logic [7:0] expCsum;
    } vec_t;

    vec_t vecs [9];
    int   total = 0;
    int   bad = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total = total + 1;
        if (actual != expected) begin
            bad = bad + 1;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic stepIn();
        @(posedge clk);
        #1;
    endtask

    task automatic fillMem(input int mul, input int add);
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * mul + add);
    endtask

    task automatic waitCapture(input int maxCycles, output bit ok, output int atCyc);
        ok = 1'b0;
        atCyc = 0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (capture) begin
                ok = 1'b1;
                atCyc = cyc;
                break;
            end
        end
    endtask

    task automatic waitIdle(input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic waitByte(input logic [7:0] val, input int maxCycles, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxCycles; i++) begin
            @(negedge clk);
            if (out_valid && out_data == val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Compares the stream captured since index s0 against an expected byte list.
    task automatic checkStream(input string name, input int s0, input logic [7:0] exp [$]);
        int got;
        int diffs;
        got = streamQ.size() - s0;
        checkOutput({name, " length"}, got, exp.size());
        if (got == exp.size()) begin
            diffs = 0;
            for (int i = 0; i < got; i++) if (streamQ[s0 + i] != exp[i]) diffs++;
            checkOutput({name, " bytes wrong"}, diffs, 0);
        end
    endtask

    // One full frame with enable dropped right after the capture pulse.
    task automatic applyStimulus(input vec_t v, input int idx);
        int         s0;
        int         c0;
        int         k0;
        int         got;
        int         diffs;
        int         atCyc;
        logic [15:0] p0;
        logic [7:0] sum;
        bit         ok;

        fillMem(v.mul, v.add);
        ramLen = ADDR_W'(v.len);
        s0 = streamQ.size();
        c0 = clampCount;
        k0 = capCount;
        p0 = pkt_count;
        stepIn();
        enable = 1'b1;
        waitCapture(50, ok, atCyc);
        checkOutput($sformatf("v%0d capture seen", idx), int'(ok), 1);
        stepIn();
        enable = 1'b0;
        waitIdle(5000, ok);
        checkOutput($sformatf("v%0d back to idle", idx), int'(ok), 1);

        got = streamQ.size() - s0;
        checkOutput($sformatf("v%0d byte count", idx), got, (v.expN == 0) ? 0 : v.expN + 4);
        checkOutput($sformatf("v%0d pkt_count delta", idx), int'(16'(pkt_count - p0)), (v.expN == 0) ? 0 : 1);
        checkOutput($sformatf("v%0d len_clamped pulses", idx), clampCount - c0, v.expClamp);
        checkOutput($sformatf("v%0d capture pulses", idx), capCount - k0, 1);

        if (v.expN != 0 && got == v.expN + 4) begin
            checkOutput($sformatf("v%0d sof", idx), int'(streamQ[s0]), int'(SOF));
            checkOutput($sformatf("v%0d len hi", idx), int'(streamQ[s0 + 1]), int'(v.expHi));
            checkOutput($sformatf("v%0d len lo", idx), int'(streamQ[s0 + 2]), int'(v.expLo));
            diffs = 0;
            sum = 8'h00;
            for (int i = 0; i < v.expN; i++) begin
                if (streamQ[s0 + 3 + i] != 8'(i * v.mul + v.add)) diffs++;
                sum = sum + streamQ[s0 + 3 + i];
            end
            checkOutput($sformatf("v%0d data bytes wrong", idx), diffs, 0);
            checkOutput($sformatf("v%0d checksum", idx), int'(streamQ[s0 + 3 + v.expN]), int'(v.expCsum));
            sum = sum + streamQ[s0 + 3 + v.expN];
            checkOutput($sformatf("v%0d sum with checksum", idx), int'(sum), 0);
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int          s0;
        int          k0;
        int          c1;
        int          c2;
        int          ackCyc;
        int          holdErr;
        logic [15:0] p0;
        bit          ok;

        //          len   mul   add   clamp hi     lo     n     csum
        vecs[0] = '{3,    1,    1,    0,    8'h00, 8'h03, 3,    8'hFA};
        vecs[1] = '{1,    1,    8'h80, 0,   8'h00, 8'h01, 1,    8'h80};
        vecs[2] = '{5,    16,   16,   0,    8'h00, 8'h05, 5,    8'h10};
        vecs[3] = '{0,    1,    1,    0,    8'h00, 8'h00, 0,    8'h00};
        vecs[4] = '{4,    0,    8'hFF, 0,   8'h00, 8'h04, 4,    8'h04};
        vecs[5] = '{256,  1,    1,    0,    8'h01, 8'h00, 256,  8'h80};
        vecs[6] = '{1518, 1,    1,    0,    8'h05, 8'hEE, 1518, 8'h67};
        vecs[7] = '{2000, 1,    1,    1,    8'h05, 8'hEE, 1518, 8'h67};
        vecs[8] = '{1519, 1,    1,    1,    8'h05, 8'hEE, 1518, 8'h67};

        fillMem(1, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset capture", int'(capture), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset pkt_count", int'(pkt_count), 0);
        checkOutput("reset pkt_addr", int'(pkt_addr), 0);
        checkOutput("reset out_data", int'(out_data), 0);
        checkOutput("reset len_clamped", int'(len_clamped), 0);
        stepIn();
        rst = 1'b0;

        for (int v = 0; v < 9; v++) applyStimulus(vecs[v], v);
        checkOutput("pkt_addr beyond MAX_LEN-1", addrOver, 0);

        // Gap timing with enable held: next capture GAP_CYCLES+1 clocks after the checksum edge.
        fillMem(1, 1);
        ramLen = 12'd3;
        s0 = streamQ.size();
        k0 = capCount;
        p0 = pkt_count;
        stepIn();
        enable = 1'b1;
        waitCapture(50, ok, c1);
        checkOutput("gap first capture", int'(ok), 1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (streamQ.size() >= s0 + 7) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("gap frame complete", int'(ok), 1);
        if (ok) begin
            checkStream("gap frame", s0, '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA});
            ackCyc = xferCyc[s0 + 6];
            waitCapture(60, ok, c2);
            checkOutput("gap second capture", int'(ok), 1);
            // Monitor cycle stamps sit one edge before the transfer they report.
            checkOutput("gap capture spacing", c2 - ackCyc, GAP_CYCLES + 2);
        end
        stepIn();
        enable = 1'b0;
        waitIdle(500, ok);
        checkOutput("gap idle", int'(ok), 1);
        checkOutput("gap capture pulses", capCount - k0, 2);
        checkOutput("gap pkt_count delta", int'(16'(pkt_count - p0)), 2);

        // Zero-length frame with enable held: nothing emitted, capture repeats after the gap.
        ramLen = 12'd0;
        s0 = streamQ.size();
        p0 = pkt_count;
        stepIn();
        enable = 1'b1;
        waitCapture(50, ok, c1);
        checkOutput("zero first capture", int'(ok), 1);
        waitCapture(100, ok, c2);
        checkOutput("zero second capture", int'(ok), 1);
        checkOutput("zero capture after done", c2 - doneRiseCyc, GAP_CYCLES + 2);
        stepIn();
        enable = 1'b0;
        waitIdle(500, ok);
        checkOutput("zero idle", int'(ok), 1);
        checkOutput("zero bytes emitted", streamQ.size() - s0, 0);
        checkOutput("zero pkt_count delta", int'(16'(pkt_count - p0)), 0);

        // Backpressure on data byte 0x02, with enable dropped while it stalls.
        fillMem(1, 1);
        ramLen = 12'd3;
        s0 = streamQ.size();
        k0 = capCount;
        p0 = pkt_count;
        stepIn();
        enable = 1'b1;
        waitByte(8'h01, 100, ok);
        checkOutput("bp first data byte", int'(ok), 1);
        stepIn();
        out_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("bp stalled valid", int'(ok), 1);
        checkOutput("bp stalled byte", int'(out_data), 8'h02);
        stepIn();
        enable = 1'b0;
        holdErr = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!out_valid || out_data != 8'h02) holdErr++;
        end
        checkOutput("bp hold violations", holdErr, 0);
        stepIn();
        out_ready = 1'b1;
        waitIdle(500, ok);
        checkOutput("bp idle", int'(ok), 1);
        checkStream("bp frame", s0, '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA});
        checkOutput("bp pkt_count delta", int'(16'(pkt_count - p0)), 1);
        repeat (40) @(negedge clk);
        checkOutput("bp no recapture", capCount - k0, 1);
        checkOutput("bp busy after idle", int'(busy), 0);

        // Reset while a data byte is pending.
        fillMem(16, 16);
        ramLen = 12'd5;
        stepIn();
        enable = 1'b1;
        waitCapture(50, ok, c1);
        checkOutput("rst capture", int'(ok), 1);
        stepIn();
        enable = 1'b0;
        waitByte(8'h20, 100, ok);
        checkOutput("rst reached data", int'(ok), 1);
        stepIn();
        out_ready = 1'b0;
        waitByte(8'h30, 10, ok);
        checkOutput("rst pending byte", int'(ok), 1);
        stepIn();
        rst = 1'b1;
        enable = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst out_valid", int'(out_valid), 0);
        checkOutput("rst pkt_addr", int'(pkt_addr), 0);
        checkOutput("rst pkt_count", int'(pkt_count), 0);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst out_data", int'(out_data), 0);
        stepIn();
        rst = 1'b0;
        s0 = streamQ.size();
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst capture after release", int'(capture), 1);
        stepIn();
        enable = 1'b0;
        waitIdle(500, ok);
        checkOutput("rst idle", int'(ok), 1);
        checkStream("rst frame", s0, '{8'hA5, 8'h00, 8'h05, 8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h10});
        checkOutput("rst pkt_count after frame", int'(pkt_count), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
